// File: rtl/enc_pipe.sv
// Two-stage SECDED (72,64) encoder with valid/ready handshake and a saturating delivery counter.
// Defining ECC_ERR_INJ_EN compiles in one-shot error injection (INJ_ARM / INJ_MASK ports).
module enc_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [63:0]      IN_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [71:0]      OUT,
    output logic [CNT_W-1:0] CNT
`ifdef ECC_ERR_INJ_EN
    ,
    input  logic             INJ_ARM,
    input  logic [71:0]      INJ_MASK
`endif
);

    // H-matrix data columns shared with dec_top: the 56 weight-3 bytes in
    // ascending order, then the first 8 weight-5 bytes; check columns are unit vectors.
    function automatic logic [63:0][7:0] build_cols();
        logic [63:0][7:0] cols;
        logic [6:0]       idx;
        int               ones;
        cols = '0;
        idx  = '0;
        for (int w = 3; w <= 5; w += 2) begin
            for (int v = 0; v < 256; v++) begin
                ones = 0;
                for (int b = 0; b < 8; b++) begin
                    if (v[b]) ones++;
                end
                if (ones == w && idx < 7'd64) begin
                    cols[idx[5:0]] = v[7:0];
                    idx            = idx + 7'd1;
                end
            end
        end
        return cols;
    endfunction

    function automatic logic [7:0][63:0] build_masks(input logic [63:0][7:0] cols);
        logic [7:0][63:0] m;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 64; i++) begin
                m[k][i] = cols[i][k];
            end
        end
        return m;
    endfunction

    localparam logic [63:0][7:0] H_COLS = build_cols();
    localparam logic [7:0][63:0] K_MASK = build_masks(H_COLS);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             s1_adv, s2_adv, s1_load, s2_load;
    logic             s1_valid_d, s1_valid_q;
    logic             out_valid_d, out_valid_q;
    logic [63:0]      data_d, data_q;
    logic [7:0][7:0]  part_d, part_q;
    logic [7:0]       chk;
    logic [71:0]      code;
    logic [71:0]      out_d, out_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
`ifdef ECC_ERR_INJ_EN
    logic             inj_armed_d, inj_armed_q;
    logic [71:0]      inj_mask_d, inj_mask_q;
`endif

    assign s2_adv  = !out_valid_q || OUT_READY;
    assign s1_adv  = !s1_valid_q || s2_adv;
    assign s1_load = IN_VALID && s1_adv;
    assign s2_load = s1_valid_q && s2_adv;

    // Stage 1: each data byte folds into its own 8-bit partial check value.
    always_comb begin
        s1_valid_d = s1_valid_q;
        data_d     = data_q;
        part_d     = part_q;
        if (s1_adv) s1_valid_d = IN_VALID;
        if (s1_load) begin
            data_d = IN_DATA;
            for (int g = 0; g < 8; g++) begin
                for (int k = 0; k < 8; k++) begin
                    part_d[g][k] = ^(IN_DATA[8*g +: 8] & K_MASK[k][8*g +: 8]);
                end
            end
        end
    end

    always_comb begin
        chk = '0;
        for (int g = 0; g < 8; g++) begin
            chk = chk ^ part_q[g];
        end
        code = {chk, data_q};

        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (s2_adv) out_valid_d = s1_valid_q;
`ifdef ECC_ERR_INJ_EN
        inj_armed_d = inj_armed_q;
        inj_mask_d  = inj_mask_q;
        if (s2_load) begin
            out_d       = inj_armed_q ? (code ^ inj_mask_q) : code;
            inj_armed_d = 1'b0;
        end
        // A new arm wins over the clear caused by a simultaneous load.
        if (INJ_ARM) begin
            inj_armed_d = 1'b1;
            inj_mask_d  = INJ_MASK;
        end
`else
        if (s2_load) out_d = code;
`endif

        cnt_d = cnt_q;
        if (out_valid_q && OUT_READY && cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
`ifdef ECC_ERR_INJ_EN
            inj_armed_q <= 1'b0;
            inj_mask_q  <= '0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
`ifdef ECC_ERR_INJ_EN
            inj_armed_q <= inj_armed_d;
            inj_mask_q  <= inj_mask_d;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        data_q <= data_d;
        part_q <= part_d;
        out_q  <= out_d;
    end

    assign IN_READY  = s1_adv;
    assign OUT_VALID = out_valid_q;
    assign OUT       = out_q;
    assign CNT       = cnt_q;

endmodule
